// File: rtl/rv_writeback_arbiter_if.sv
// rv_writeback_arbiter_if: writeback beat bus from the commit arbiter to the register file and scoreboard
interface rv_writeback_arbiter_if #(
    parameter int UUID_BITS   = 44,
    parameter int NW_BITS     = 2,
    parameter int NUM_THREADS = 4,
    parameter int NR_BITS     = 5
);
    logic                      valid;
    logic [UUID_BITS-1:0]      uuid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [NW_BITS-1:0]        wid;
    logic [31:0]               PC;
    logic [NR_BITS-1:0]        rd;
    logic [NUM_THREADS*32-1:0] data;
    logic                      eop;
    logic                      ready;
    modport master (output valid, uuid, tmask, wid, PC, rd, data, eop, input ready);
    modport slave (input valid, uuid, tmask, wid, PC, rd, data, eop, output ready);
endinterface

// File: rtl/rv_writeback_arbiter.sv
// rv_writeback_arbiter: round-robin commit arbiter with packet lock driving a registered writeback stage
module rv_writeback_arbiter #(
    parameter int CORE_ID     = 0,
    parameter int NUM_REQS    = 4,
    parameter int UUID_BITS   = 44,
    parameter int NW_BITS     = 2,
    parameter int NUM_THREADS = 4,
    parameter int NR_BITS     = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                commit_valid,
    output logic [NUM_REQS-1:0]                commit_ready,
    input  logic [NUM_REQS*UUID_BITS-1:0]      commit_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]        commit_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]    commit_tmask,
    input  logic [NUM_REQS*32-1:0]             commit_PC,
    input  logic [NUM_REQS-1:0]                commit_wb,
    input  logic [NUM_REQS*NR_BITS-1:0]        commit_rd,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] commit_data,
    input  logic [NUM_REQS-1:0]                commit_eop,
    rv_writeback_arbiter_if.master             writeback_if
);
    localparam int IW = $clog2(NUM_REQS);
    localparam int DW = NUM_THREADS * 32;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQS - 1);

    if (NUM_REQS < 2 || CORE_ID < 0) begin : g_bad_cfg
        $error("rv_writeback_arbiter: NUM_REQS must be >= 2 and CORE_ID non-negative");
    end

    logic [IW-1:0] ptr, lock_idx, grant_idx;
    logic          locked, grant_any, can_accept, xfer;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return IW'(s >= NUM_REQS ? s - NUM_REQS : s);
    endfunction

    // Descending scan so the source nearest the pointer is written last and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = lock_idx;
        if (locked)
            grant_any = commit_valid[lock_idx];
        else
            for (int k = NUM_REQS - 1; k >= 0; k--)
                if (commit_valid[rr_idx(ptr, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_idx(ptr, k);
                end
    end

    assign can_accept   = ~writeback_if.valid | writeback_if.ready;
    assign xfer         = grant_any & can_accept & ~reset;
    assign commit_ready = xfer ? (NUM_REQS'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            writeback_if.valid <= 1'b0;
            writeback_if.uuid  <= '0;
            writeback_if.tmask <= '0;
            writeback_if.wid   <= '0;
            writeback_if.PC    <= '0;
            writeback_if.rd    <= '0;
            writeback_if.data  <= '0;
            writeback_if.eop   <= 1'b0;
            ptr                <= '0;
            lock_idx           <= '0;
            locked             <= 1'b0;
        end else begin
            if (xfer && commit_wb[grant_idx]) begin
                writeback_if.valid <= 1'b1;
                writeback_if.uuid  <= commit_uuid[grant_idx*UUID_BITS +: UUID_BITS];
                writeback_if.tmask <= commit_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
                writeback_if.wid   <= commit_wid[grant_idx*NW_BITS +: NW_BITS];
                writeback_if.PC    <= commit_PC[grant_idx*32 +: 32];
                writeback_if.rd    <= commit_rd[grant_idx*NR_BITS +: NR_BITS];
                writeback_if.data  <= commit_data[grant_idx*DW +: DW];
                writeback_if.eop   <= commit_eop[grant_idx];
            end else if (writeback_if.ready)
                writeback_if.valid <= 1'b0;
            // Pointer only advances at packet end so multi-beat packets stay contiguous.
            if (xfer) begin
                locked   <= ~commit_eop[grant_idx];
                lock_idx <= grant_idx;
                if (commit_eop[grant_idx])
                    ptr <= grant_idx == LAST ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rv_writeback_arbiter.sv
// tb_rv_writeback_arbiter: directed and random checks of the writeback arbiter against a queue-style reference model
module tb_rv_writeback_arbiter;
  localparam int N = 4, UB = 44, WB = 2, NT = 4, RB = 5, DW = NT * 32;
  typedef struct packed {
    logic [UB-1:0] uuid;
    logic [NT-1:0] tmask;
    logic [WB-1:0] wid;
    logic [31:0]   pc;
    logic [RB-1:0] rd;
    logic [DW-1:0] data;
    logic          eop;
  } beat_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]    commit_valid, commit_ready, commit_wb, commit_eop;
  logic [N*UB-1:0] commit_uuid;
  logic [N*WB-1:0] commit_wid;
  logic [N*NT-1:0] commit_tmask;
  logic [N*32-1:0] commit_PC;
  logic [N*RB-1:0] commit_rd;
  logic [N*DW-1:0] commit_data;
  rv_writeback_arbiter_if #(.UUID_BITS(UB), .NW_BITS(WB), .NUM_THREADS(NT), .NR_BITS(RB)) wb_if();
  rv_writeback_arbiter #(.CORE_ID(0), .NUM_REQS(N), .UUID_BITS(UB), .NW_BITS(WB), .NUM_THREADS(NT), .NR_BITS(RB)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_uuid(commit_uuid), .commit_wid(commit_wid), .commit_tmask(commit_tmask), .commit_PC(commit_PC),
    .commit_wb(commit_wb), .commit_rd(commit_rd), .commit_data(commit_data), .commit_eop(commit_eop),
    .writeback_if(wb_if)
  );
  int vectors = 0, miscompares = 0;
  beat_t m_out = '0;
  bit m_valid = 1'b0;
  int m_ptr = 0, m_lock = -1;
  logic [N-1:0] last_ready;
  logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  function automatic beat_t src_beat(input int i);
    return beat_t'{uuid: commit_uuid[i*UB +: UB], tmask: commit_tmask[i*NT +: NT], wid: commit_wid[i*WB +: WB],
                   pc: commit_PC[i*32 +: 32], rd: commit_rd[i*RB +: RB], data: commit_data[i*DW +: DW], eop: commit_eop[i]};
  endfunction
  function automatic beat_t dut_beat();
    return {wb_if.uuid, wb_if.tmask, wb_if.wid, wb_if.PC, wb_if.rd, wb_if.data, wb_if.eop};
  endfunction
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rand_payload();
    for (int b = 0; b < N*UB; b++) commit_uuid[b] = 1'($urandom);
    for (int b = 0; b < N*WB; b++) commit_wid[b] = 1'($urandom);
    for (int b = 0; b < N*NT; b++) commit_tmask[b] = 1'($urandom);
    for (int b = 0; b < N*32; b++) commit_PC[b] = 1'($urandom);
    for (int b = 0; b < N*RB; b++) commit_rd[b] = 1'($urandom);
    for (int b = 0; b < N*DW; b++) commit_data[b] = 1'($urandom);
  endtask
  task automatic clear_srcs();
    commit_valid = '0;
    commit_wb = '1;
    commit_eop = '1;
    rand_payload();
  endtask
  // One cycle: predict the grant from the priority rules, then the output register after the edge.
  task automatic step();
    int g;
    bit can;
    logic [N-1:0] er;
    can = !m_valid || wb_if.ready;
    g = -1;
    if (!reset) begin
      if (m_lock >= 0) begin
        if (commit_valid[m_lock]) g = m_lock;
      end else
        for (int k = 0; k < N && g < 0; k++)
          if (commit_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    er = (g >= 0 && can) ? N'(1) << g : '0;
    last_ready = er;
    #1 check("commit_ready", commit_ready, er);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_out = '0; m_ptr = 0; m_lock = -1;
    end else begin
      if (wb_if.ready) m_valid = 1'b0;
      if (er != 0) begin
        if (commit_wb[g]) begin m_valid = 1'b1; m_out = src_beat(g); end
        m_lock = commit_eop[g] ? -1 : g;
        if (commit_eop[g]) m_ptr = (g + 1) % N;
      end
    end
    @(negedge clk);
    check("wb_valid", wb_if.valid, m_valid);
    check("wb_payload", dut_beat(), m_out);
  endtask
  initial begin
    wb_if.ready = 1'b1;
    clear_srcs();
    step();
    check("rst_valid", wb_if.valid, 1'b0);
    check("rst_payload", dut_beat(), '0);
    check("rst_ready", commit_ready, '0);
    reset = 1'b0;
    clear_srcs();
    commit_valid[0] = 1'b1;
    commit_wid[0 +: WB] = 2'd1;
    commit_rd[0 +: RB] = 5'd5;
    commit_data[0 +: DW] = {NT{32'h11}};
    step();
    check("alu_ready", last_ready, 4'b0001);
    check("alu_rd", wb_if.rd, 5'd5);
    check("alu_wid", wb_if.wid, 2'd1);
    check("alu_eop", wb_if.eop, 1'b1);
    check("alu_data", wb_if.data, {NT{32'h11}});
    clear_srcs();
    step();
    check("alu_drain", wb_if.valid, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      commit_valid = '1;
      step();
      check("rr_grant", last_ready, rr_exp[k]);
      check("rr_nobubble", wb_if.valid, 1'b1);
    end
    clear_srcs();
    commit_valid[2] = 1'b1;
    wb_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready", last_ready, 4'b0000);
    end
    wb_if.ready = 1'b1;
    step();
    check("bp_go", last_ready, 4'b0100);
    check("bp_go_rd", wb_if.rd, commit_rd[2*RB +: RB]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_srcs();
    commit_valid[0] = 1'b1;
    step();
    commit_valid = 4'b0011;
    commit_eop[1] = 1'b0;
    step();
    check("lock_b0", last_ready, 4'b0010);
    commit_valid[1] = 1'b0;
    step();
    check("lock_hold", last_ready, 4'b0000);
    commit_valid[1] = 1'b1;
    step();
    check("lock_b1", last_ready, 4'b0010);
    commit_eop[1] = 1'b1;
    step();
    check("lock_b2", last_ready, 4'b0010);
    commit_valid[1] = 1'b0;
    step();
    check("lock_after", last_ready, 4'b0001);
    clear_srcs();
    commit_valid[3] = 1'b1;
    commit_wb[3] = 1'b0;
    step();
    check("drop_ready", last_ready, 4'b1000);
    check("drop_valid", wb_if.valid, 1'b0);
    clear_srcs();
    commit_valid = 4'b0011;
    step();
    check("ptr_wrap", last_ready, 4'b0001);
    clear_srcs();
    commit_valid[2] = 1'b1;
    commit_eop[2] = 1'b0;
    step();
    check("pre_rst_valid", wb_if.valid, 1'b1);
    reset = 1'b1;
    step();
    check("mid_rst_ready", last_ready, 4'b0000);
    check("mid_rst_valid", wb_if.valid, 1'b0);
    reset = 1'b0;
    clear_srcs();
    commit_valid = 4'b0011;
    step();
    check("post_rst_grant", last_ready, 4'b0001);
    for (int n = 0; n < 400; n++) begin
      rand_payload();
      for (int i = 0; i < N; i++) begin
        commit_valid[i] = $urandom_range(99) < 60;
        commit_wb[i] = $urandom_range(99) < 80;
        commit_eop[i] = 1'($urandom_range(1));
      end
      wb_if.ready = $urandom_range(99) < 70;
      reset = $urandom_range(99) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
